// File: rtl/cpu_pkg.sv
// cpu_pkg: shared control-word types for the 5-stage pipeline control tracker.
package cpu_pkg;

  localparam logic [2:0] ALUOP_ADD   = 3'b000;
  localparam logic [2:0] ALUOP_SUB   = 3'b001;
  localparam logic [2:0] ALUOP_RTYPE = 3'b010;
  localparam logic [2:0] ALUOP_AND   = 3'b011;
  localparam logic [2:0] ALUOP_OR    = 3'b100;
  localparam logic [2:0] ALUOP_SLT   = 3'b101;
  localparam logic [2:0] ALUOP_NOP   = 3'b111;

  typedef struct packed {
    logic       reg_dst;
    logic       branch;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       alu_src;
    logic       reg_write;
    logic [2:0] alu_op;
  } ctrl_t;

  localparam ctrl_t CTRL_BUBBLE = '{reg_dst: 1'b0, branch: 1'b0, mem_read: 1'b0,
                                    mem_write: 1'b0, mem_to_reg: 1'b0, alu_src: 1'b0,
                                    reg_write: 1'b0, alu_op: ALUOP_NOP};

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_t;

endpackage

// File: rtl/cpu_hazard_unit.sv
// cpu_hazard_unit: combinational stall / flush / EX forwarding-select logic.
// CPU_FORWARDING_EN defined: forwarding plus load-use stalls only.
// CPU_FORWARDING_EN undefined: no forwarding, stall on any EX/MEM producer.
module cpu_hazard_unit import cpu_pkg::*; #(
  parameter int REG_AW = 5
) (
  input  logic [2:0]        id_alu_op,
  input  logic              id_alu_src,
  input  logic              id_mem_write,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              ex_mem_read,
  input  logic              ex_reg_write,
  input  logic [REG_AW-1:0] ex_rs,
  input  logic [REG_AW-1:0] ex_rt,
  input  logic [REG_AW-1:0] ex_dst,
  input  logic              mem_reg_write,
  input  logic              mem_branch,
  input  logic [REG_AW-1:0] mem_dst,
  input  logic              wb_reg_write,
  input  logic [REG_AW-1:0] wb_dst,
  input  logic              mem_zero,
  output logic              stall,
  output logic              flush,
  output fwd_sel_t          fwd_a,
  output fwd_sel_t          fwd_b
);

  logic id_live, use_rs, use_rt, raw_stall;

  // An invalid/no-op instruction in ID consumes nothing; r0 never matches.
  assign id_live = (id_alu_op != ALUOP_NOP);
  assign use_rs  = id_live && (id_rs != '0);
  assign use_rt  = id_live && (!id_alu_src || id_mem_write) && (id_rt != '0);

  function automatic logic src_hit(input logic we, input logic [REG_AW-1:0] dst,
                                   input logic urs, input logic [REG_AW-1:0] rs,
                                   input logic urt, input logic [REG_AW-1:0] rt);
    return we && (dst != '0) && ((urs && dst == rs) || (urt && dst == rt));
  endfunction

  assign flush = mem_branch & mem_zero;

`ifdef CPU_FORWARDING_EN
  function automatic fwd_sel_t pick(input logic [REG_AW-1:0] src,
                                    input logic m_we, input logic [REG_AW-1:0] m_dst,
                                    input logic w_we, input logic [REG_AW-1:0] w_dst);
    if (m_we && m_dst != '0 && m_dst == src)      return FWD_MEM;
    else if (w_we && w_dst != '0 && w_dst == src) return FWD_WB;
    else                                          return FWD_RF;
  endfunction

  logic unused_fwd;
  assign unused_fwd = ex_reg_write;

  // Only a load in EX cannot be forwarded in time.
  assign raw_stall = src_hit(ex_mem_read, ex_dst, use_rs, id_rs, use_rt, id_rt);

  // MEM result is newer than WB, so it wins.
  always_comb begin
    fwd_a = pick(ex_rs, mem_reg_write, mem_dst, wb_reg_write, wb_dst);
    fwd_b = pick(ex_rt, mem_reg_write, mem_dst, wb_reg_write, wb_dst);
  end
`else
  logic unused_fwd;
  assign unused_fwd = ^{ex_mem_read, ex_rs, ex_rt, wb_reg_write, wb_dst};

  // Without bypass paths, wait until every producer has reached WB.
  assign raw_stall = src_hit(ex_reg_write, ex_dst, use_rs, id_rs, use_rt, id_rt) ||
                     src_hit(mem_reg_write, mem_dst, use_rs, id_rs, use_rt, id_rt);

  always_comb begin
    fwd_a = FWD_RF;
    fwd_b = FWD_RF;
  end
`endif

  // A taken branch squashes the stalled instruction anyway.
  assign stall = raw_stall & ~flush;

endmodule

// File: rtl/cpu_pipe_ctrl.sv
// cpu_pipe_ctrl: carries decoded controls through ID/EX, EX/MEM, MEM/WB and
// applies stall bubbles and branch flushes. Optional CPU_FORWARDING_EN selects
// EX forwarding instead of full producer stalls (see cpu_hazard_unit).
module cpu_pipe_ctrl import cpu_pkg::*; #(
  parameter int REG_AW = 5
) (
  input  logic              clock__i,
  input  logic              reset_n__i,
  input  logic              RegDst__i,
  input  logic              Branch__i,
  input  logic              MemRead__i,
  input  logic              MemWrite__i,
  input  logic              MemToReg__i,
  input  logic              ALUSrc__i,
  input  logic              RegWrite__i,
  input  logic [2:0]        ALUOp__i,
  input  logic [REG_AW-1:0] id_rs__i,
  input  logic [REG_AW-1:0] id_rt__i,
  input  logic [REG_AW-1:0] id_rd__i,
  input  logic              mem_zero__i,
  output logic              ex_RegDst__o,
  output logic              ex_ALUSrc__o,
  output logic [2:0]        ex_ALUOp__o,
  output logic              mem_MemRead__o,
  output logic              mem_MemWrite__o,
  output logic              mem_Branch__o,
  output logic              wb_MemToReg__o,
  output logic              wb_RegWrite__o,
  output logic [REG_AW-1:0] wb_dst__o,
  output logic [1:0]        fwd_a__o,
  output logic [1:0]        fwd_b__o,
  output logic              stall__o,
  output logic              flush__o
);

  typedef struct packed {
    ctrl_t             ctrl;
    logic [REG_AW-1:0] rs;
    logic [REG_AW-1:0] rt;
    logic [REG_AW-1:0] rd;
  } idex_t;

  typedef struct packed {
    ctrl_t             ctrl;
    logic [REG_AW-1:0] dst;
  } stg_t;

  localparam idex_t IDEX_BUBBLE = '{ctrl: CTRL_BUBBLE, rs: '0, rt: '0, rd: '0};
  localparam stg_t  STG_BUBBLE  = '{ctrl: CTRL_BUBBLE, dst: '0};

  ctrl_t             id_ctrl;
  idex_t             ex_q;
  stg_t              mem_q, wb_q;
  logic [REG_AW-1:0] ex_dst;
  logic              stall, flush;
  fwd_sel_t          fwd_a, fwd_b;
  logic              unused_wb;

  assign id_ctrl = '{reg_dst: RegDst__i, branch: Branch__i, mem_read: MemRead__i,
                     mem_write: MemWrite__i, mem_to_reg: MemToReg__i, alu_src: ALUSrc__i,
                     reg_write: RegWrite__i, alu_op: ALUOp__i};

  assign ex_dst = ex_q.ctrl.reg_dst ? ex_q.rd : ex_q.rt;

  cpu_hazard_unit #(.REG_AW(REG_AW)) u_hazard (
    .id_alu_op     (ALUOp__i),
    .id_alu_src    (ALUSrc__i),
    .id_mem_write  (MemWrite__i),
    .id_rs         (id_rs__i),
    .id_rt         (id_rt__i),
    .ex_mem_read   (ex_q.ctrl.mem_read),
    .ex_reg_write  (ex_q.ctrl.reg_write),
    .ex_rs         (ex_q.rs),
    .ex_rt         (ex_q.rt),
    .ex_dst        (ex_dst),
    .mem_reg_write (mem_q.ctrl.reg_write),
    .mem_branch    (mem_q.ctrl.branch),
    .mem_dst       (mem_q.dst),
    .wb_reg_write  (wb_q.ctrl.reg_write),
    .wb_dst        (wb_q.dst),
    .mem_zero      (mem_zero__i),
    .stall         (stall),
    .flush         (flush),
    .fwd_a         (fwd_a),
    .fwd_b         (fwd_b)
  );

  // Stage registers: stall bubbles ID/EX, flush bubbles ID/EX and EX/MEM,
  // MEM/WB always advances.
  always_ff @(posedge clock__i or negedge reset_n__i) begin
    if (!reset_n__i) begin
      ex_q  <= IDEX_BUBBLE;
      mem_q <= STG_BUBBLE;
      wb_q  <= STG_BUBBLE;
    end else begin
      if (flush || stall) ex_q <= IDEX_BUBBLE;
      else                ex_q <= '{ctrl: id_ctrl, rs: id_rs__i, rt: id_rt__i, rd: id_rd__i};
      if (flush) mem_q <= STG_BUBBLE;
      else       mem_q <= '{ctrl: ex_q.ctrl, dst: ex_dst};
      wb_q <= mem_q;
    end
  end

  // WB only consumes the write-back controls; earlier-stage fields die here.
  assign unused_wb = ^{wb_q.ctrl.reg_dst, wb_q.ctrl.branch, wb_q.ctrl.mem_read,
                       wb_q.ctrl.mem_write, wb_q.ctrl.alu_src, wb_q.ctrl.alu_op};

  assign ex_RegDst__o    = ex_q.ctrl.reg_dst;
  assign ex_ALUSrc__o    = ex_q.ctrl.alu_src;
  assign ex_ALUOp__o     = ex_q.ctrl.alu_op;
  assign mem_MemRead__o  = mem_q.ctrl.mem_read;
  assign mem_MemWrite__o = mem_q.ctrl.mem_write;
  assign mem_Branch__o   = mem_q.ctrl.branch;
  assign wb_MemToReg__o  = wb_q.ctrl.mem_to_reg;
  assign wb_RegWrite__o  = wb_q.ctrl.reg_write;
  assign wb_dst__o       = wb_q.dst;
  assign fwd_a__o        = fwd_a;
  assign fwd_b__o        = fwd_b;
  assign stall__o        = stall;
  assign flush__o        = flush;

endmodule

// File: tb/tb_cpu_pipe_ctrl.sv
// tb_cpu_pipe_ctrl: directed vectors for cpu_pipe_ctrl, both forwarding builds.
module tb_cpu_pipe_ctrl;
  localparam int AW = 5;

  // {RegDst, Branch, MemRead, MemWrite, MemToReg, ALUSrc, RegWrite, ALUOp}
  localparam logic [9:0] I_RTYPE = 10'b1_0_0_0_0_0_1_010;
  localparam logic [9:0] I_ADDI  = 10'b0_0_0_0_0_1_1_000;
  localparam logic [9:0] I_LW    = 10'b0_0_1_0_1_1_1_000;
  localparam logic [9:0] I_SW    = 10'b0_0_0_1_0_1_0_000;
  localparam logic [9:0] I_BEQ   = 10'b0_1_0_0_0_0_0_001;
  localparam logic [9:0] I_NOP   = 10'b0_0_0_0_0_0_0_111;

  logic          clock__i = 1'b0;
  logic          reset_n__i;
  logic          RegDst__i, Branch__i, MemRead__i, MemWrite__i, MemToReg__i, ALUSrc__i, RegWrite__i;
  logic [2:0]    ALUOp__i;
  logic [AW-1:0] id_rs__i, id_rt__i, id_rd__i;
  logic          mem_zero__i;
  logic          ex_RegDst__o, ex_ALUSrc__o;
  logic [2:0]    ex_ALUOp__o;
  logic          mem_MemRead__o, mem_MemWrite__o, mem_Branch__o;
  logic          wb_MemToReg__o, wb_RegWrite__o;
  logic [AW-1:0] wb_dst__o;
  logic [1:0]    fwd_a__o, fwd_b__o;
  logic          stall__o, flush__o;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clock__i = ~clock__i;

  cpu_pipe_ctrl #(.REG_AW(AW)) dut (
    .clock__i(clock__i), .reset_n__i(reset_n__i),
    .RegDst__i(RegDst__i), .Branch__i(Branch__i), .MemRead__i(MemRead__i),
    .MemWrite__i(MemWrite__i), .MemToReg__i(MemToReg__i), .ALUSrc__i(ALUSrc__i),
    .RegWrite__i(RegWrite__i), .ALUOp__i(ALUOp__i),
    .id_rs__i(id_rs__i), .id_rt__i(id_rt__i), .id_rd__i(id_rd__i),
    .mem_zero__i(mem_zero__i),
    .ex_RegDst__o(ex_RegDst__o), .ex_ALUSrc__o(ex_ALUSrc__o), .ex_ALUOp__o(ex_ALUOp__o),
    .mem_MemRead__o(mem_MemRead__o), .mem_MemWrite__o(mem_MemWrite__o),
    .mem_Branch__o(mem_Branch__o), .wb_MemToReg__o(wb_MemToReg__o),
    .wb_RegWrite__o(wb_RegWrite__o), .wb_dst__o(wb_dst__o),
    .fwd_a__o(fwd_a__o), .fwd_b__o(fwd_b__o), .stall__o(stall__o), .flush__o(flush__o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic id_set(input logic [9:0] c, input logic [AW-1:0] rs, rt, rd);
    {RegDst__i, Branch__i, MemRead__i, MemWrite__i, MemToReg__i, ALUSrc__i,
     RegWrite__i, ALUOp__i} = c;
    id_rs__i = rs; id_rt__i = rt; id_rd__i = rd;
  endtask

  task automatic tick();
    @(posedge clock__i); #1;
  endtask

  task automatic drain();
    id_set(I_NOP, 0, 0, 0);
    repeat (3) tick();
  endtask

  initial begin
    reset_n__i = 1'b0; mem_zero__i = 1'b0;
    id_set(I_NOP, 0, 0, 0);
    repeat (2) @(posedge clock__i);
    @(negedge clock__i);
    chk("rst_ex_aluop", ex_ALUOp__o, 3'b111);
    chk("rst_ex_regdst", ex_RegDst__o, 0);
    chk("rst_ex_alusrc", ex_ALUSrc__o, 0);
    chk("rst_mem_ctl", {mem_MemRead__o, mem_MemWrite__o, mem_Branch__o}, 0);
    chk("rst_wb_ctl", {wb_MemToReg__o, wb_RegWrite__o}, 0);
    chk("rst_wb_dst", wb_dst__o, 0);
    chk("rst_fwd", {fwd_a__o, fwd_b__o}, 0);
    chk("rst_stall_flush", {stall__o, flush__o}, 0);
    reset_n__i = 1'b1;

    // Flow: ADDI r5,r1 ; LW r6,(r2) ; SW r7,(r3)
    tick(); id_set(I_ADDI, 1, 5, 0);
    tick(); id_set(I_LW, 2, 6, 0);
    @(negedge clock__i);
    chk("addi_ex", {ex_RegDst__o, ex_ALUSrc__o, ex_ALUOp__o}, 5'b0_1_000);
    chk("flow_stall0", stall__o, 0);
    tick(); id_set(I_SW, 3, 7, 0);
    @(negedge clock__i);
    chk("lw_ex", {ex_RegDst__o, ex_ALUSrc__o, ex_ALUOp__o}, 5'b0_1_000);
    chk("addi_mem", {mem_MemRead__o, mem_MemWrite__o, mem_Branch__o}, 3'b000);
    chk("flow_stall1", stall__o, 0);
    tick(); id_set(I_NOP, 0, 0, 0);
    @(negedge clock__i);
    chk("lw_mem", {mem_MemRead__o, mem_MemWrite__o}, 2'b10);
    chk("addi_wb", {wb_MemToReg__o, wb_RegWrite__o}, 2'b01);
    chk("addi_wb_dst", wb_dst__o, 5);
    tick();
    @(negedge clock__i);
    chk("sw_mem", {mem_MemRead__o, mem_MemWrite__o}, 2'b01);
    chk("lw_wb", {wb_MemToReg__o, wb_RegWrite__o}, 2'b11);
    chk("lw_wb_dst", wb_dst__o, 6);
    chk("nop_ex_aluop", ex_ALUOp__o, 3'b111);
    tick();
    @(negedge clock__i);
    chk("sw_wb", {wb_MemToReg__o, wb_RegWrite__o}, 2'b00);
    chk("sw_wb_dst", wb_dst__o, 7);
    drain();

`ifdef CPU_FORWARDING_EN
    // Load-use: LW r8 ; ADD r9,r8,r2
    id_set(I_LW, 1, 8, 0); tick();
    id_set(I_RTYPE, 8, 2, 9);
    @(negedge clock__i);
    chk("lu_stall", stall__o, 1);
    tick();
    @(negedge clock__i);
    chk("lu_stall_1cyc", stall__o, 0);
    chk("lu_bubble", ex_ALUOp__o, 3'b111);
    tick(); id_set(I_NOP, 0, 0, 0);
    @(negedge clock__i);
    chk("lu_add_ex", {ex_RegDst__o, ex_ALUOp__o}, 4'b1_010);
    chk("lu_fwd_a", fwd_a__o, 2'b01);
    chk("lu_fwd_b", fwd_b__o, 2'b00);
    drain();

    // ADD r3,r1,r2 ; SUB r4,r3,r3
    id_set(I_RTYPE, 1, 2, 3); tick();
    id_set(I_RTYPE, 3, 3, 4);
    @(negedge clock__i);
    chk("fw_nostall", stall__o, 0);
    tick(); id_set(I_NOP, 0, 0, 0);
    @(negedge clock__i);
    chk("fw_mem_ab", {fwd_a__o, fwd_b__o}, 4'b10_10);
    drain();

    // ADD r0,r1,r2 ; SUB r4,r0,r0
    id_set(I_RTYPE, 1, 2, 0); tick();
    id_set(I_RTYPE, 0, 0, 4); tick();
    id_set(I_NOP, 0, 0, 0);
    @(negedge clock__i);
    chk("fw_r0", {fwd_a__o, fwd_b__o}, 4'b00_00);
    drain();

    // ADD r3 ; ADD r3 ; SUB r4,r3,r6 -> newer MEM copy wins
    id_set(I_RTYPE, 1, 2, 3); tick();
    id_set(I_RTYPE, 1, 1, 3); tick();
    id_set(I_RTYPE, 3, 6, 4); tick();
    id_set(I_NOP, 0, 0, 0);
    @(negedge clock__i);
    chk("fw_prio_a", fwd_a__o, 2'b10);
    chk("fw_prio_b", fwd_b__o, 2'b00);
    drain();
`else
    // ADD r3,r1,r2 ; SUB r4,r3,r5 -> two stall cycles, no forwarding
    id_set(I_RTYPE, 1, 2, 3); tick();
    id_set(I_RTYPE, 3, 5, 4);
    @(negedge clock__i);
    chk("nf_stall_c0", stall__o, 1);
    chk("nf_fwd_c0", {fwd_a__o, fwd_b__o}, 0);
    tick();
    @(negedge clock__i);
    chk("nf_stall_c1", stall__o, 1);
    chk("nf_bubble", ex_ALUOp__o, 3'b111);
    tick();
    @(negedge clock__i);
    chk("nf_stall_c2", stall__o, 0);
    tick(); id_set(I_NOP, 0, 0, 0);
    @(negedge clock__i);
    chk("nf_sub_ex", {ex_RegDst__o, ex_ALUOp__o}, 4'b1_010);
    chk("nf_fwd_c3", {fwd_a__o, fwd_b__o}, 0);
    drain();

    // rt only counts as a source for non-immediate ops and stores
    id_set(I_RTYPE, 1, 2, 3); tick();
    id_set(I_ADDI, 1, 3, 0);
    @(negedge clock__i);
    chk("nf_addi_rt_unused", stall__o, 0);
    id_set(I_SW, 1, 3, 0); #1;
    chk("nf_sw_rt_used", stall__o, 1);
    drain();
`endif

    // Taken branch in MEM while a load-use stall is pending
    id_set(I_BEQ, 1, 2, 0); tick();
    id_set(I_LW, 4, 8, 0); tick();
    id_set(I_RTYPE, 8, 2, 9); mem_zero__i = 1'b0;
    @(negedge clock__i);
    chk("br_mem_branch", mem_Branch__o, 1);
    chk("br_nt_stall", stall__o, 1);
    chk("br_nt_flush", flush__o, 0);
    mem_zero__i = 1'b1; #1;
    chk("br_flush", flush__o, 1);
    chk("br_stall_masked", stall__o, 0);
    tick(); id_set(I_NOP, 0, 0, 0); mem_zero__i = 1'b0;
    @(negedge clock__i);
    chk("br_ex_bubble", {ex_RegDst__o, ex_ALUSrc__o, ex_ALUOp__o}, 5'b0_0_111);
    chk("br_mem_bubble", {mem_MemRead__o, mem_MemWrite__o, mem_Branch__o}, 0);
    chk("br_after", {stall__o, flush__o}, 0);
    tick();
    @(negedge clock__i);
    chk("br_lw_squashed", wb_RegWrite__o, 0);
    drain();

    // Reset mid-stream clears everything immediately
    id_set(I_LW, 1, 8, 0); tick();
    id_set(I_ADDI, 2, 9, 0); tick();
    id_set(I_NOP, 0, 0, 0); #1;
    chk("pre_rst_mem_rd", mem_MemRead__o, 1);
    reset_n__i = 1'b0; #1;
    chk("mid_rst_ex_aluop", ex_ALUOp__o, 3'b111);
    chk("mid_rst_mem_rd", mem_MemRead__o, 0);
    chk("mid_rst_wb", {wb_RegWrite__o, wb_dst__o}, 0);
    @(negedge clock__i); reset_n__i = 1'b1;
    tick(); tick();
    @(negedge clock__i);
    chk("post_rst_empty", {mem_MemRead__o, wb_RegWrite__o, wb_dst__o}, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
